// File: rtl/usb_upload_packetizer.sv
// Buffers the unthrottled upload byte stream in a FIFO and cuts it into USB bulk-IN packets
// of up to MAX_PKT bytes, flushing a partial packet after FLUSH_TIMEOUT idle cycles.
module usb_upload_packetizer #(
  parameter int FIFO_DEPTH    = 2048,
  parameter int MAX_PKT       = 512,
  parameter int FLUSH_TIMEOUT = 1000,
  localparam int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic [7:0]        ep_data_o,
  output logic              ep_valid_o,
  input  logic              ep_ready_i,
  output logic              ep_last_o,
  output logic [ADDR_W:0]   fifo_level_o,
  output logic              overflow_o,
  output logic [15:0]       drop_count_o,
  input  logic              clear_overflow_i
);
  localparam int LVL_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [LVL_W-1:0] DEPTH_C = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] MAXP_C  = LVL_W'(MAX_PKT);
  localparam logic [TMR_W-1:0] TMO_C   = TMR_W'(FLUSH_TIMEOUT);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

  state_e            state_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d, pkt_len_q, issued_q, loaded_q;
  logic [TMR_W-1:0]  timer_q;
  logic [7:0]        ram_q, ep_data_q;
  logic              ram_vld_q, ep_valid_q, ep_last_q, overflow_q;
  logic [15:0]       drop_cnt_q;
  logic              wr_en, drop, hs, last_hs, load, rd_en;

  // Handshake decode; the RAM stage refills whenever it is empty or being moved to the output
  always_comb begin
    wr_en   = in_valid_i && (level_q < DEPTH_C);
    drop    = in_valid_i && (level_q >= DEPTH_C);
    hs      = ep_valid_q && ep_ready_i;
    last_hs = hs && ep_last_q;
    load    = ram_vld_q && (!ep_valid_q || ep_ready_i);
    rd_en   = (state_q == ST_SEND) && (issued_q != pkt_len_q) && (!ram_vld_q || load);
    case ({wr_en, hs})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Byte storage with synchronous read; contents need no reset since pointers do
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data_i;
    if (rd_en) ram_q <= mem_q[rd_ptr_q];
  end

  // Control, counters and registered endpoint outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_len_q  <= '0;
      issued_q   <= '0;
      loaded_q   <= '0;
      timer_q    <= '0;
      ram_vld_q  <= 1'b0;
      ep_valid_q <= 1'b0;
      ep_data_q  <= 8'd0;
      ep_last_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      level_q <= level_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);

      // A drop in the same cycle as a clear restarts the count at one
      if (clear_overflow_i) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= 16'd0;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (clear_overflow_i) drop_cnt_q <= 16'd1;
        else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end

      if (in_valid_i || last_hs) timer_q <= '0;
      else if ((state_q == ST_IDLE) && (level_q != '0) && (timer_q != TMO_C))
        timer_q <= timer_q + TMR_W'(1);

      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        issued_q <= issued_q + LVL_W'(1);
      end
      if (rd_en) ram_vld_q <= 1'b1;
      else if (load) ram_vld_q <= 1'b0;

      if (load) begin
        ep_valid_q <= 1'b1;
        ep_data_q  <= ram_q;
        ep_last_q  <= (loaded_q == pkt_len_q - LVL_W'(1));
        loaded_q   <= loaded_q + LVL_W'(1);
      end else if (hs) begin
        ep_valid_q <= 1'b0;
        ep_last_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (level_q >= MAXP_C) begin
            state_q   <= ST_SEND;
            pkt_len_q <= MAXP_C;
            issued_q  <= '0;
            loaded_q  <= '0;
          end else if ((level_q != '0) && (timer_q == TMO_C)) begin
            state_q   <= ST_SEND;
            pkt_len_q <= level_q;
            issued_q  <= '0;
            loaded_q  <= '0;
          end
        end
        ST_SEND: begin
          if (last_hs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ep_data_o    = ep_data_q;
  assign ep_valid_o   = ep_valid_q;
  assign ep_last_o    = ep_last_q;
  assign fifo_level_o = level_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_usb_upload_packetizer.sv
// Randomised and directed bench for usb_upload_packetizer against a transaction-level
// model built from a byte queue, a level count and the packet-start rules.
module tb_usb_upload_packetizer;
  localparam int DEPTH = 2048;
  localparam int MAXP  = 512;
  localparam int TMO   = 1000;

  logic        clk = 1'b0;
  logic        rst_i, in_valid_i, ep_ready_i, clear_overflow_i;
  logic [7:0]  in_data_i, ep_data_o;
  logic        ep_valid_o, ep_last_o, overflow_o;
  logic [11:0] fifo_level_o;
  logic [15:0] drop_count_o;

  int n_checks = 0;
  int n_errors = 0;

  byte unsigned exp_q[$];
  int  pkt_sizes[$];
  int  m_lvl, m_tmr, m_drop, m_pkt_len, m_hs_cnt, m_wait, cur_len, tog;
  bit  m_ovf, m_busy, m_started;

  always #5 clk = ~clk;

  usb_upload_packetizer #(.FIFO_DEPTH(DEPTH), .MAX_PKT(MAXP), .FLUSH_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .ep_data_o(ep_data_o), .ep_valid_o(ep_valid_o), .ep_ready_i(ep_ready_i),
    .ep_last_o(ep_last_o), .fifo_level_o(fifo_level_o), .overflow_o(overflow_o),
    .drop_count_o(drop_count_o), .clear_overflow_i(clear_overflow_i)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int pkt_at(input int i);
    return (i < pkt_sizes.size()) ? pkt_sizes[i] : -1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pkt_sizes.delete();
    m_lvl = 0; m_tmr = 0; m_drop = 0; m_pkt_len = 0; m_hs_cnt = 0; m_wait = 0; cur_len = 0;
    m_ovf = 1'b0; m_busy = 1'b0; m_started = 1'b0;
  endtask

  // One clock: apply inputs, score any handshake, advance the model, then check after the edge
  task automatic tick(input bit v, input byte unsigned d, input bit rdy, input bit clr);
    bit hs, wr, dr, lhs, start, stall, pl;
    byte unsigned pd;
    in_valid_i = v; in_data_i = d; ep_ready_i = rdy; clear_overflow_i = clr;
    hs  = ep_valid_o && rdy;
    lhs = 1'b0;
    if (hs) begin
      check_eq("hs_in_packet", int'(m_busy), 1);
      check_eq("hs_queue_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_eq("ep_data", int'(ep_data_o), int'(exp_q.pop_front()));
      lhs = m_busy && (m_hs_cnt == m_pkt_len - 1);
      check_eq("ep_last", int'(ep_last_o), int'(lhs));
      m_hs_cnt++;
      cur_len++;
      if (ep_last_o) begin
        pkt_sizes.push_back(cur_len);
        cur_len = 0;
      end
    end
    stall = ep_valid_o && !rdy;
    pd = ep_data_o;
    pl = ep_last_o;
    wr = v && (m_lvl < DEPTH);
    dr = v && !wr;
    if (wr) exp_q.push_back(d);
    start = !m_busy && ((m_lvl >= MAXP) || (m_lvl > 0 && m_tmr == TMO));
    if (v || lhs) m_tmr = 0;
    else if (!m_busy && m_lvl > 0 && m_tmr < TMO) m_tmr++;
    if (clr) begin m_ovf = 1'b0; m_drop = 0; end
    if (dr) begin m_ovf = 1'b1; if (m_drop < 65535) m_drop++; end
    if (start) begin
      m_busy = 1'b1; m_started = 1'b0; m_hs_cnt = 0; m_wait = 0;
      m_pkt_len = (m_lvl >= MAXP) ? MAXP : m_lvl;
    end
    if (lhs) m_busy = 1'b0;
    m_lvl = m_lvl + int'(wr) - int'(hs);
    @(posedge clk);
    #1;
    check_eq("fifo_level", int'(fifo_level_o), m_lvl);
    check_eq("overflow", int'(overflow_o), int'(m_ovf));
    check_eq("drop_count", int'(drop_count_o), m_drop);
    if (stall) begin
      check_eq("stall_valid", int'(ep_valid_o), 1);
      check_eq("stall_data", int'(ep_data_o), int'(pd));
      check_eq("stall_last", int'(ep_last_o), int'(pl));
    end
    if (!m_busy) check_eq("valid_outside_packet", int'(ep_valid_o), 0);
    else if (m_started) check_eq("no_bubble", int'(ep_valid_o), 1);
    else if (ep_valid_o) m_started = 1'b1;
    else begin
      m_wait++;
      check_eq("first_valid_latency", int'(m_wait > 2), 0);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; in_valid_i = 1'b0; ep_ready_i = 1'b1; clear_overflow_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_clear();
    check_eq("rst_valid", int'(ep_valid_o), 0);
    check_eq("rst_last", int'(ep_last_o), 0);
    check_eq("rst_data", int'(ep_data_o), 0);
    check_eq("rst_level", int'(fifo_level_o), 0);
    check_eq("rst_overflow", int'(overflow_o), 0);
    check_eq("rst_drop", int'(drop_count_o), 0);
  endtask

  // mode 0: ready high, 1: random ready, 2: ready toggling each cycle
  function automatic bit rdy_of(input int mode);
    tog++;
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return 1'(tog & 1);
    return 1'b1;
  endfunction

  task automatic drain(input int budget, input int mode);
    int n = 0;
    while ((m_busy || m_lvl > 0) && n < budget) begin
      tick(1'b0, 8'd0, rdy_of(mode), 1'b0);
      n++;
    end
    check_eq("drain_done", int'(m_busy || m_lvl > 0), 0);
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = 8'd0; ep_ready_i = 1'b1;
    clear_overflow_i = 1'b0; tog = 0;
    model_clear();
    do_reset();

    // 512 back-to-back bytes form exactly one full packet
    for (int i = 0; i < 512; i++) tick(1'b1, 8'(i), 1'b1, 1'b0);
    drain(3000, 0);
    check_eq("t1_npkts", pkt_sizes.size(), 1);
    check_eq("t1_len", pkt_at(0), 512);

    // Three bytes then silence: flushed only after the timeout
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    drain(3000, 0);
    check_eq("t2_npkts", pkt_sizes.size(), 1);
    check_eq("t2_len", pkt_at(0), 3);

    // 1300 continuous bytes: 512 + 512 + timed-out remainder
    do_reset();
    for (int i = 0; i < 1300; i++) tick(1'b1, 8'(i * 3), 1'b1, 1'b0);
    drain(5000, 0);
    check_eq("t3_npkts", pkt_sizes.size(), 3);
    check_eq("t3_len0", pkt_at(0), 512);
    check_eq("t3_len1", pkt_at(1), 512);
    check_eq("t3_len2", pkt_at(2), 276);

    // Endpoint stalled: fill, overflow by two, clear interplay, then drain
    do_reset();
    for (int i = 0; i < 2050; i++) tick(1'b1, 8'(i * 7 + 1), 1'b0, 1'b0);
    check_eq("t4_level_full", int'(fifo_level_o), 2048);
    check_eq("t4_overflow", int'(overflow_o), 1);
    check_eq("t4_drops", int'(drop_count_o), 2);
    tick(1'b1, 8'hEE, 1'b0, 1'b1);
    check_eq("t4_clr_drop_ovf", int'(overflow_o), 1);
    check_eq("t4_clr_drop_cnt", int'(drop_count_o), 1);
    tick(1'b0, 8'd0, 1'b0, 1'b1);
    check_eq("t4_clr_ovf", int'(overflow_o), 0);
    check_eq("t4_clr_cnt", int'(drop_count_o), 0);
    drain(6000, 0);
    check_eq("t4_npkts", pkt_sizes.size(), 4);
    check_eq("t4_len3", pkt_at(3), 512);

    // Ready toggling every cycle during a packet, then a random mix
    do_reset();
    for (int i = 0; i < 700; i++) tick(1'b1, 8'($urandom), rdy_of(2), 1'b0);
    drain(6000, 2);
    for (int i = 0; i < 3000; i++)
      tick(1'($urandom_range(0, 3) != 0), 8'($urandom), rdy_of(1),
           1'($urandom_range(0, 199) == 0));
    drain(8000, 1);

    // Reset in the middle of a packet, then a fresh packet
    do_reset();
    for (int i = 0; i < 512; i++) tick(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) tick(1'b0, 8'd0, 1'b1, 1'b0);
    check_eq("t6_mid_packet", int'(m_busy && ep_valid_o), 1);
    do_reset();
    for (int i = 0; i < 512; i++) tick(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    drain(3000, 0);
    check_eq("t6_npkts", pkt_sizes.size(), 1);
    check_eq("t6_len", pkt_at(0), 512);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
